shift_unit: RTL and testbench

//  Parametrised, multi-cycle shifter for the ARM datapath; generalises the single-bit left shifter.

---
 rtl/shift_pkg.sv | 19 +
 rtl/shift_step.sv | 43 ++++
 rtl/shift_unit.sv | 145 ++++++++++++++
 tb/tb_shift_unit.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types for the multi-cycle shifter: operation codes and FSM states.
// The optional carry path is selected by the SHIFT_CARRY_EN macro in the consuming files.
package shift_pkg;
  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    LSL = 3'd0,
    LSR = 3'd1,
    ASR = 3'd2,
    ROR = 3'd3,
    RRX = 3'd4
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shift_state_t;
endpackage

// File: rtl/shift_step.sv
// Combinational one-bit shift step; cout is the bit that leaves the word.
// Unknown op codes pass data and carry through untouched.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  shift_op_t        op,
  input  logic [WIDTH-1:0] data,
  input  logic             cin,
  output logic [WIDTH-1:0] data_next,
  output logic             cout
);

  always_comb begin
    data_next = data;
    cout      = cin;
    case (op)
      LSL: begin
        data_next = {data[WIDTH-2:0], 1'b0};
        cout      = data[WIDTH-1];
      end
      LSR: begin
        data_next = {1'b0, data[WIDTH-1:1]};
        cout      = data[0];
      end
      ASR: begin
        data_next = {data[WIDTH-1], data[WIDTH-1:1]};
        cout      = data[0];
      end
      ROR: begin
        data_next = {data[0], data[WIDTH-1:1]};
        cout      = data[0];
      end
      RRX: begin
        data_next = {cin, data[WIDTH-1:1]};
        cout      = data[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/shift_unit.sv
// Multi-cycle LSL/LSR/ASR/ROR/RRX shifter, one bit per clock, valid/ready on both sides.
// Define SHIFT_CARRY_EN to add carry_in/carry_out and enable RRX; otherwise op 4 is pass-through.
module shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AMT_W = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [OP_W-1:0]  in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef SHIFT_CARRY_EN
  ,
  input  logic             carry_in,
  output logic             carry_out
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int EXT_W = (AMT_W > CNT_W) ? AMT_W : CNT_W;

  shift_state_t     state_reg, state_next;
  logic [WIDTH-1:0] data_reg;
  logic [CNT_W-1:0] count_reg;
  shift_op_t        op_reg;
  logic             zc_reg;
  logic             carry_reg;

  logic [EXT_W-1:0] amt_ext;
  logic [CNT_W-1:0] amt_sat, amt_rot, count_init;
  logic             zero_carry, ror_wrap;
  logic [WIDTH-1:0] step_data;
  logic             step_cin, step_cout;

  assign amt_ext = EXT_W'(in_amt);
  assign amt_sat = (amt_ext > EXT_W'(WIDTH)) ? CNT_W'(WIDTH) : CNT_W'(amt_ext);
  assign amt_rot = CNT_W'(amt_ext & EXT_W'(WIDTH - 1));

  // Request decode: the iteration count plus the two carry special cases
  // that plain bit-stepping cannot produce (over-range LSL/LSR, ROR by k*WIDTH).
  always_comb begin
    count_init = '0;
    zero_carry = 1'b0;
    ror_wrap   = 1'b0;
    case (in_op)
      LSL, LSR: begin
        count_init = amt_sat;
        zero_carry = amt_ext > EXT_W'(WIDTH);
      end
      ASR: count_init = amt_sat;
      ROR: begin
        count_init = amt_rot;
        ror_wrap   = (amt_ext != '0) && (amt_rot == '0);
      end
`ifdef SHIFT_CARRY_EN
      RRX: count_init = CNT_W'(1);
`endif
      default: ;
    endcase
  end

`ifdef SHIFT_CARRY_EN
  assign step_cin  = carry_reg;
  assign carry_out = carry_reg;
`else
  assign step_cin  = 1'b0;
  logic unused_carry;
  assign unused_carry = ^{zc_reg, ror_wrap, step_cout, carry_reg};
`endif

  shift_step #(.WIDTH(WIDTH)) u_step (
    .op       (op_reg),
    .data     (data_reg),
    .cin      (step_cin),
    .data_next(step_data),
    .cout     (step_cout)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = (count_init != '0) ? SHIFT : DONE;
      end
      SHIFT: if (count_reg == CNT_W'(1)) state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_reg  <= '0;
      count_reg <= '0;
      op_reg    <= LSL;
      zc_reg    <= 1'b0;
      carry_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (in_valid) begin
          data_reg  <= in_data;
          op_reg    <= shift_op_t'(in_op);
          count_reg <= count_init;
          zc_reg    <= zero_carry;
`ifdef SHIFT_CARRY_EN
          carry_reg <= ror_wrap ? in_data[WIDTH-1] : carry_in;
`else
          carry_reg <= 1'b0;
`endif
        end
        SHIFT: begin
          data_reg  <= step_data;
          count_reg <= count_reg - CNT_W'(1);
          // Shifting further than the word leaves nothing behind, carry included.
          carry_reg <= (zc_reg && count_reg == CNT_W'(1)) ? 1'b0 : step_cout;
        end
        default: ;
      endcase
    end
  end

  assign out_data = data_reg;

endmodule

// File: tb/tb_shift_unit.sv
// Directed bench for shift_unit (WIDTH=16, AMT_W=5); carry checks and RRX follow SHIFT_CARRY_EN.
module tb_shift_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_data, out_data;
  logic [4:0]  in_amt;
  logic [2:0]  in_op;
`ifdef SHIFT_CARRY_EN
  logic        carry_in, carry_out;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 clock = ~clock;

  shift_unit #(.WIDTH(16), .AMT_W(5)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_amt   (in_amt),
    .in_op    (in_op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`ifdef SHIFT_CARRY_EN
    ,
    .carry_in (carry_in),
    .carry_out(carry_out)
`endif
  );

  typedef struct {
    logic [2:0]  op;
    logic [15:0] d;
    logic [4:0]  a;
    logic        c;
    logic [15:0] ed;
    logic        ec;
    int          lat;
  } vec_t;

  // Drives one request, scrambles the inputs after acceptance, waits for the
  // result (bounded) and completes the output handshake. Latency counts the
  // accepting edge as edge 1.
  task automatic run_op(input logic [2:0] op, input logic [15:0] data, input logic [4:0] amt,
                        input logic cin, output logic [15:0] res, output logic cout, output int lat);
    @(negedge clock);
    in_valid = 1'b1;
    in_op    = op;
    in_data  = data;
    in_amt   = amt;
`ifdef SHIFT_CARRY_EN
    carry_in = cin;
`endif
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_data  = 16'hDEAD;
    in_amt   = 5'd7;
    in_op    = 3'd1;
`ifdef SHIFT_CARRY_EN
    carry_in = ~cin;
`endif
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clock);
      #1;
      lat++;
    end
    res = out_data;
`ifdef SHIFT_CARRY_EN
    cout = carry_out;
`else
    cout = cin;
`endif
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0;
    in_amt    = 5'd0;
    in_op     = 3'd0;
    out_ready = 1'b0;
`ifdef SHIFT_CARRY_EN
    carry_in  = 1'b0;
`endif
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0) begin
      fails++;
      $display("FAIL reset_hold out_valid=%b out_data=%h want 0/0000", out_valid, out_data);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 16'h0) begin
      fails++;
      $display("FAIL reset_release in_ready=%b out_valid=%b out_data=%h want 1/0/0000",
               in_ready, out_valid, out_data);
    end
`ifdef SHIFT_CARRY_EN
    checks++;
    if (carry_out !== 1'b0) begin
      fails++;
      $display("FAIL reset_carry got %b want 0", carry_out);
    end
`endif
    $display("reset: in_ready=%b out_valid=%b out_data=%h", in_ready, out_valid, out_data);
  endtask

  task automatic test_shift_ops();
    vec_t        vecs[14];
    logic [15:0] res;
    logic        cout;
    int          lat;
    vecs = '{
      '{3'd0, 16'h000B, 5'd1,  1'b0, 16'h0016, 1'b0, 2},
      '{3'd0, 16'h0001, 5'd1,  1'b1, 16'h0002, 1'b0, 2},
      '{3'd1, 16'h8001, 5'd16, 1'b0, 16'h0000, 1'b1, 17},
      '{3'd1, 16'h8001, 5'd20, 1'b1, 16'h0000, 1'b0, 17},
      '{3'd2, 16'h8000, 5'd3,  1'b1, 16'hF000, 1'b0, 4},
      '{3'd3, 16'h0001, 5'd17, 1'b0, 16'h8000, 1'b1, 2},
      '{3'd4, 16'h0003, 5'd9,  1'b1, 16'h8001, 1'b1, 2},
      '{3'd0, 16'h1234, 5'd0,  1'b1, 16'h1234, 1'b1, 1},
      '{3'd6, 16'h1234, 5'd9,  1'b0, 16'h1234, 1'b0, 1},
      '{3'd3, 16'h8001, 5'd16, 1'b0, 16'h8001, 1'b1, 1},
      '{3'd2, 16'h8000, 5'd20, 1'b0, 16'hFFFF, 1'b1, 17},
      '{3'd2, 16'h4000, 5'd31, 1'b1, 16'h0000, 1'b0, 17},
      '{3'd0, 16'h8001, 5'd16, 1'b0, 16'h0000, 1'b1, 17},
      '{3'd3, 16'h00F1, 5'd4,  1'b1, 16'h100F, 1'b0, 5}
    };
`ifndef SHIFT_CARRY_EN
    vecs[6].ed  = 16'h0003;
    vecs[6].lat = 1;
`endif
    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].op, vecs[i].d, vecs[i].a, vecs[i].c, res, cout, lat);
      $display("op=%0d data=%h amt=%0d cin=%b -> data=%h carry=%b latency=%0d",
               vecs[i].op, vecs[i].d, vecs[i].a, vecs[i].c, res, cout, lat);
      checks++;
      if (res !== vecs[i].ed) begin
        fails++;
        $display("FAIL vec%0d_data got %h want %h", i, res, vecs[i].ed);
      end
      checks++;
      if (lat !== vecs[i].lat) begin
        fails++;
        $display("FAIL vec%0d_latency got %0d want %0d", i, lat, vecs[i].lat);
      end
`ifdef SHIFT_CARRY_EN
      checks++;
      if (cout !== vecs[i].ec) begin
        fails++;
        $display("FAIL vec%0d_carry got %b want %b", i, cout, vecs[i].ec);
      end
`endif
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    @(negedge clock);
    in_valid = 1'b1;
    in_op    = 3'd0;
    in_data  = 16'h000B;
    in_amt   = 5'd1;
    @(posedge clock);
    #1;
    // Queue a second request that must wait for the handshake.
    in_data = 16'h0001;
    in_amt  = 5'd3;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clock);
      #1;
      lat++;
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || out_data !== 16'h0016 || in_ready !== 1'b0) bad++;
      @(posedge clock);
      #1;
    end
    checks++;
    if (bad != 0 || lat != 2) begin
      fails++;
      $display("FAIL backpressure_hold bad_cycles=%0d latency=%0d want 0/2", bad, lat);
    end
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL backpressure_release out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL backpressure_accept in_ready=%b out_valid=%b want 0/0", in_ready, out_valid);
    end
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clock);
      #1;
      lat++;
    end
    checks++;
    if (out_data !== 16'h0008 || lat != 4) begin
      fails++;
      $display("FAIL backpressure_second data=%h latency=%0d want 0008/4", out_data, lat);
    end
    $display("backpressure: second result data=%h latency=%0d", out_data, lat);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_abort();
    logic [15:0] res;
    logic        cout;
    int          lat;
    int          spurious;
    @(negedge clock);
    in_valid = 1'b1;
    in_op    = 3'd0;
    in_data  = 16'h0001;
    in_amt   = 5'd10;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 16'h0) begin
      fails++;
      $display("FAIL abort_outputs out_valid=%b in_ready=%b out_data=%h want 0/1/0000",
               out_valid, in_ready, out_data);
    end
`ifdef SHIFT_CARRY_EN
    checks++;
    if (carry_out !== 1'b0) begin
      fails++;
      $display("FAIL abort_carry got %b want 0", carry_out);
    end
`endif
    @(negedge clock);
    reset_n  = 1'b1;
    spurious = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clock);
      #1;
      if (out_valid === 1'b1) spurious++;
    end
    checks++;
    if (spurious != 0) begin
      fails++;
      $display("FAIL abort_no_valid got %0d valid cycles want 0", spurious);
    end
    run_op(3'd0, 16'h0003, 5'd2, 1'b0, res, cout, lat);
    $display("after abort: op=0 data=0003 amt=2 -> data=%h carry=%b latency=%0d", res, cout, lat);
    checks++;
    if (res !== 16'h000C || lat != 3) begin
      fails++;
      $display("FAIL abort_next data=%h latency=%0d want 000c/3", res, lat);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_shift_ops();
    test_backpressure();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
